sweep_scheduler: RTL and testbench

- Sequences one frequency sweep of the impedance-measurement core.
- Steps the DDS frequency-table index from a first to a last entry and waits a programmable settling time at each point.
- Triggers the measurement core 2^avg_log2 times per point and averages the returned modulus/phase pairs.
- Writes one averaged result per point into the result RAM for the host. Sits between the host register block and the measurement/DDS datapath.

---
 rtl/sweep_scheduler.sv | 243 ++++++++++++++++++++++++
 tb/tb_sweep_scheduler.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_scheduler.sv
// Sweep sequencer for the impedance-measurement core: steps the DDS index,
// settles, triggers and averages repeated measurements, and writes one result per point.
module sweep_scheduler #(
    parameter int unsigned IDX_W        = 8,
    parameter int unsigned RES_W        = 32,
    parameter int unsigned AVG_MAX_LOG2 = 4,
    parameter int unsigned SETTLE_W     = 16,
    parameter int unsigned TMO_W        = 24
) (
    input  logic                clk125,
    input  logic                areset_n,
    input  logic                go,
    input  logic                abort,
    input  logic [IDX_W-1:0]    cfg_first_idx,
    input  logic [IDX_W-1:0]    cfg_last_idx,
    input  logic [2:0]          cfg_avg_log2,
    input  logic [SETTLE_W-1:0] cfg_settle,
    input  logic [TMO_W-1:0]    cfg_timeout,
    output logic [IDX_W-1:0]    freq_idx,
    output logic                meas_start,
    input  logic                meas_valid,
    input  logic [RES_W-1:0]    meas_mod,
    input  logic [RES_W-1:0]    meas_phase,
    output logic                res_we,
    output logic [IDX_W-1:0]    res_addr,
    output logic [RES_W-1:0]    res_mod,
    output logic [RES_W-1:0]    res_phase,
    output logic                busy,
    output logic                done,
    output logic                timeout_err,
    output logic [IDX_W:0]      points_done
);

    localparam int unsigned ACC_W = RES_W + AVG_MAX_LOG2;
    localparam int unsigned REP_W = (AVG_MAX_LOG2 > 0) ? AVG_MAX_LOG2 : 1;
    localparam int unsigned PTS_W = IDX_W + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_TRIG   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_STORE  = 3'd4;
    localparam logic [2:0] S_NEXT   = 3'd5;
    localparam logic [2:0] S_FINISH = 3'd6;

    logic [2:0]              state, state_d;
    logic [SETTLE_W-1:0]     settle_cnt, settle_cnt_d;
    logic [TMO_W-1:0]        tmo_cnt, tmo_cnt_d;
    logic [REP_W-1:0]        rep, rep_d;
    logic signed [ACC_W-1:0] acc_mod, acc_mod_d;
    logic signed [ACC_W-1:0] acc_phase, acc_phase_d;

    // Sweep configuration captured on the accepted go
    logic [IDX_W-1:0]        first_q, first_d;
    logic [IDX_W-1:0]        last_q, last_d;
    logic [2:0]              avg_q, avg_d;
    logic [SETTLE_W-1:0]     settle_q, settle_d;
    logic [TMO_W-1:0]        timeout_q, timeout_d;

    logic [IDX_W-1:0]        freq_idx_d;
    logic                    meas_start_d;
    logic                    res_we_d;
    logic [IDX_W-1:0]        res_addr_d;
    logic [RES_W-1:0]        res_mod_d;
    logic [RES_W-1:0]        res_phase_d;
    logic                    busy_d;
    logic                    done_d;
    logic                    timeout_err_d;
    logic [PTS_W-1:0]        points_done_d;

    logic [REP_W-1:0]        rep_last_c;
    logic [2:0]              avg_clamp_c;

    assign rep_last_c  = REP_W'((32'd1 << avg_q) - 32'd1);
    assign avg_clamp_c = (cfg_avg_log2 > 3'(AVG_MAX_LOG2)) ? 3'(AVG_MAX_LOG2) : cfg_avg_log2;

    // Next-state and next-output logic
    always_comb begin
        state_d       = state;
        settle_cnt_d  = settle_cnt;
        tmo_cnt_d     = tmo_cnt;
        rep_d         = rep;
        acc_mod_d     = acc_mod;
        acc_phase_d   = acc_phase;
        first_d       = first_q;
        last_d        = last_q;
        avg_d         = avg_q;
        settle_d      = settle_q;
        timeout_d     = timeout_q;
        freq_idx_d    = freq_idx;
        meas_start_d  = 1'b0;
        res_we_d      = 1'b0;
        res_addr_d    = res_addr;
        res_mod_d     = res_mod;
        res_phase_d   = res_phase;
        busy_d        = busy;
        done_d        = 1'b0;
        timeout_err_d = timeout_err;
        points_done_d = points_done;

        case (state)
            S_IDLE: begin
                if (go) begin
                    first_d       = cfg_first_idx;
                    last_d        = cfg_last_idx;
                    avg_d         = avg_clamp_c;
                    settle_d      = cfg_settle;
                    timeout_d     = cfg_timeout;
                    timeout_err_d = 1'b0;
                    points_done_d = '0;
                    acc_mod_d     = '0;
                    acc_phase_d   = '0;
                    rep_d         = '0;
                    busy_d        = 1'b1;
                    if (cfg_first_idx > cfg_last_idx) begin
                        state_d = S_FINISH;
                    end else begin
                        freq_idx_d   = cfg_first_idx;
                        settle_cnt_d = cfg_settle;
                        state_d      = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_FINISH;
                end else if (settle_cnt == '0) begin
                    state_d = S_TRIG;
                end else begin
                    settle_cnt_d = settle_cnt - SETTLE_W'(1);
                end
            end
            S_TRIG: begin
                if (abort) begin
                    state_d = S_FINISH;
                end else begin
                    meas_start_d = 1'b1;
                    tmo_cnt_d    = timeout_q;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                // A result in the expiry cycle still counts
                if (abort) begin
                    state_d = S_FINISH;
                end else if (meas_valid) begin
                    acc_mod_d   = acc_mod + $signed({{AVG_MAX_LOG2{meas_mod[RES_W-1]}}, meas_mod});
                    acc_phase_d = acc_phase + $signed({{AVG_MAX_LOG2{meas_phase[RES_W-1]}}, meas_phase});
                    if (rep == rep_last_c) begin
                        state_d = S_STORE;
                    end else begin
                        rep_d   = rep + REP_W'(1);
                        state_d = S_TRIG;
                    end
                end else if (tmo_cnt <= TMO_W'(1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_FINISH;
                end else begin
                    tmo_cnt_d = tmo_cnt - TMO_W'(1);
                end
            end
            S_STORE: begin
                res_we_d      = 1'b1;
                res_addr_d    = freq_idx - first_q;
                res_mod_d     = RES_W'(acc_mod >>> avg_q);
                res_phase_d   = RES_W'(acc_phase >>> avg_q);
                points_done_d = points_done + PTS_W'(1);
                acc_mod_d     = '0;
                acc_phase_d   = '0;
                rep_d         = '0;
                state_d       = abort ? S_FINISH : S_NEXT;
            end
            S_NEXT: begin
                if (abort || (freq_idx == last_q)) begin
                    state_d = S_FINISH;
                end else begin
                    freq_idx_d   = freq_idx + IDX_W'(1);
                    settle_cnt_d = settle_q;
                    state_d      = S_SETTLE;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk125 or negedge areset_n) begin
        if (!areset_n) begin
            state       <= S_IDLE;
            settle_cnt  <= '0;
            tmo_cnt     <= '0;
            rep         <= '0;
            acc_mod     <= '0;
            acc_phase   <= '0;
            first_q     <= '0;
            last_q      <= '0;
            avg_q       <= '0;
            settle_q    <= '0;
            timeout_q   <= '0;
            freq_idx    <= '0;
            meas_start  <= 1'b0;
            res_we      <= 1'b0;
            res_addr    <= '0;
            res_mod     <= '0;
            res_phase   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            points_done <= '0;
        end else begin
            state       <= state_d;
            settle_cnt  <= settle_cnt_d;
            tmo_cnt     <= tmo_cnt_d;
            rep         <= rep_d;
            acc_mod     <= acc_mod_d;
            acc_phase   <= acc_phase_d;
            first_q     <= first_d;
            last_q      <= last_d;
            avg_q       <= avg_d;
            settle_q    <= settle_d;
            timeout_q   <= timeout_d;
            freq_idx    <= freq_idx_d;
            meas_start  <= meas_start_d;
            res_we      <= res_we_d;
            res_addr    <= res_addr_d;
            res_mod     <= res_mod_d;
            res_phase   <= res_phase_d;
            busy        <= busy_d;
            done        <= done_d;
            timeout_err <= timeout_err_d;
            points_done <= points_done_d;
        end
    end

endmodule

// File: tb/tb_sweep_scheduler.sv
// Directed bench for sweep_scheduler: a reply model for the measurement core
// plus one task per scenario with hand-computed expectations.
module tb_sweep_scheduler;

    logic        clk125 = 1'b0;
    logic        areset_n;
    logic        go, abort;
    logic [7:0]  cfg_first_idx, cfg_last_idx;
    logic [2:0]  cfg_avg_log2;
    logic [15:0] cfg_settle;
    logic [23:0] cfg_timeout;
    logic [7:0]  freq_idx;
    logic        meas_start, meas_valid;
    logic [31:0] meas_mod, meas_phase;
    logic        res_we;
    logic [7:0]  res_addr;
    logic [31:0] res_mod, res_phase;
    logic        busy, done, timeout_err;
    logic [8:0]  points_done;

    always #4 clk125 = ~clk125;

    sweep_scheduler #(.IDX_W(8), .RES_W(32), .AVG_MAX_LOG2(4), .SETTLE_W(16), .TMO_W(24)) dut (
        .clk125(clk125), .areset_n(areset_n), .go(go), .abort(abort),
        .cfg_first_idx(cfg_first_idx), .cfg_last_idx(cfg_last_idx),
        .cfg_avg_log2(cfg_avg_log2), .cfg_settle(cfg_settle), .cfg_timeout(cfg_timeout),
        .freq_idx(freq_idx), .meas_start(meas_start), .meas_valid(meas_valid),
        .meas_mod(meas_mod), .meas_phase(meas_phase), .res_we(res_we), .res_addr(res_addr),
        .res_mod(res_mod), .res_phase(res_phase), .busy(busy), .done(done),
        .timeout_err(timeout_err), .points_done(points_done)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int go_cyc;

    // Measurement-core model: replies resp_delay cycles after a visible meas_start
    int  resp_delay = 20;
    int  resp_skip  = -1;
    int  resp_mode  = 0;
    int  resp_n     = 0;
    bit  pend       = 1'b0;
    int  pend_cnt   = 0;
    int  pend_idx   = 0;
    int  tbl_mod [4];
    int  tbl_ph  [4];

    int ms_count, ms_first, ms_last, done_count, done_cyc, we_count, mv_last, we_last;
    logic [7:0]  we_addr [$];
    logic [31:0] we_mod  [$];
    logic [31:0] we_ph   [$];

    always @(negedge clk125) begin
        cyc++;
        meas_valid = 1'b0;
        if (pend) begin
            if (pend_cnt == 0) begin
                meas_valid = 1'b1;
                if (resp_mode == 0) begin
                    meas_mod   = 32'(1000 + pend_idx);
                    meas_phase = 32'(-pend_idx);
                end else begin
                    meas_mod   = 32'(tbl_mod[resp_n % 4]);
                    meas_phase = 32'(tbl_ph[resp_n % 4]);
                end
                resp_n++;
                pend    = 1'b0;
                mv_last = cyc;
            end else begin
                pend_cnt--;
            end
        end
        if (meas_start === 1'b1) begin
            ms_count++;
            if (ms_count == 1) ms_first = cyc;
            ms_last = cyc;
            if (int'(freq_idx) != resp_skip) begin
                pend     = 1'b1;
                pend_cnt = resp_delay - 1;
                pend_idx = int'(freq_idx);
            end
        end
        if (res_we === 1'b1) begin
            we_count++;
            we_last = cyc;
            we_addr.push_back(res_addr);
            we_mod.push_back(res_mod);
            we_ph.push_back(res_phase);
        end
        if (done === 1'b1) begin
            done_count++;
            done_cyc = cyc;
        end
    end

    task automatic clear_mon();
        ms_count = 0; ms_first = 0; ms_last = 0; done_count = 0; done_cyc = 0;
        we_count = 0; mv_last = 0; we_last = 0; resp_n = 0; pend = 1'b0;
        we_addr.delete(); we_mod.delete(); we_ph.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk125);
            #1;
        end
    endtask

    task automatic start_sweep(input int first, input int last, input int avg,
                               input int settle, input int tmo);
        @(negedge clk125);
        #1;
        cfg_first_idx = 8'(first);
        cfg_last_idx  = 8'(last);
        cfg_avg_log2  = 3'(avg);
        cfg_settle    = 16'(settle);
        cfg_timeout   = 24'(tmo);
        go            = 1'b1;
        go_cyc        = cyc;
        tick(1);
        go = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n = 0;
        while (done_count == 0 && n < budget) begin
            tick(1);
            n++;
        end
        ok = (done_count != 0);
    endtask

    task automatic test_reset();
        areset_n = 1'b0;
        go = 1'b0; abort = 1'b0; meas_valid = 1'b0; meas_mod = '0; meas_phase = '0;
        cfg_first_idx = '0; cfg_last_idx = '0; cfg_avg_log2 = '0; cfg_settle = '0; cfg_timeout = '0;
        tick(3);
        n_vec++;
        if ({busy, done, meas_start, res_we, timeout_err} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b expected 00000", {busy, done, meas_start, res_we, timeout_err});
        end
        areset_n = 1'b1;
        tick(2);
        n_vec++;
        if ({freq_idx, res_addr, points_done} !== 25'd0 || res_mod !== 32'd0 || res_phase !== 32'd0) begin
            n_bad++; $display("FAIL reset_data: got idx %0d addr %0d pts %0d mod %0d expected all 0", freq_idx, res_addr, points_done, res_mod);
        end
    endtask

    task automatic test_basic();
        bit ok;
        clear_mon(); resp_mode = 0; resp_delay = 20; resp_skip = -1;
        start_sweep(3, 5, 0, 10, 1000);
        n_vec++;
        if (busy !== 1'b1 || freq_idx !== 8'd3) begin
            n_bad++; $display("FAIL basic_go: got busy %b idx %0d expected 1 3", busy, freq_idx);
        end
        cfg_first_idx = 8'd77; cfg_last_idx = 8'd200; cfg_settle = 16'd1;
        wait_done(2000, ok);
        n_vec++;
        if (!ok) begin n_bad++; $display("FAIL basic_done: got no done expected done"); end
        // meas_start rises settle+2 edges after the go-sampling edge: visible settle+3 cycles on
        n_vec++;
        if (ms_first - go_cyc !== 13) begin
            n_bad++; $display("FAIL basic_start_lat: got %0d expected 13", ms_first - go_cyc);
        end
        n_vec++;
        if (we_count !== 3 || ms_count !== 3) begin
            n_bad++; $display("FAIL basic_counts: got we %0d ms %0d expected 3 3", we_count, ms_count);
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (we_addr[i] !== 8'(i) || we_mod[i] !== 32'(1003 + i) || int'(we_ph[i]) !== -(3 + i)) begin
                n_bad++; $display("FAIL basic_write%0d: got addr %0d mod %0d ph %0d expected %0d %0d %0d",
                                  i, we_addr[i], we_mod[i], $signed(we_ph[i]), i, 1003 + i, -(3 + i));
            end
        end
        n_vec++;
        if (we_last - mv_last !== 2) begin
            n_bad++; $display("FAIL basic_we_lat: got %0d expected 2", we_last - mv_last);
        end
        n_vec++;
        if (points_done !== 9'd3 || timeout_err !== 1'b0 || busy !== 1'b0 || freq_idx !== 8'd5) begin
            n_bad++; $display("FAIL basic_end: got pts %0d terr %b busy %b idx %0d expected 3 0 0 5", points_done, timeout_err, busy, freq_idx);
        end
        tick(3);
        n_vec++;
        if (done_count !== 1 || done !== 1'b0) begin
            n_bad++; $display("FAIL basic_one_done: got %0d pulses expected 1", done_count);
        end
    endtask

    task automatic test_average();
        bit ok;
        clear_mon(); resp_mode = 1; resp_delay = 3;
        tbl_mod[0] = 10; tbl_mod[1] = 11; tbl_mod[2] = 12; tbl_mod[3] = -5;
        tbl_ph[0]  = -7; tbl_ph[1]  = -8; tbl_ph[2]  = -9; tbl_ph[3]  = -10;
        start_sweep(0, 0, 2, 0, 100);
        wait_done(500, ok);
        n_vec++;
        if (!ok || ms_count !== 4 || we_count !== 1) begin
            n_bad++; $display("FAIL avg_counts: got done %b ms %0d we %0d expected 1 4 1", ok, ms_count, we_count);
        end
        n_vec++;
        if (we_addr[0] !== 8'd0 || we_mod[0] !== 32'd7 || int'(we_ph[0]) !== -9) begin
            n_bad++; $display("FAIL avg_value: got addr %0d mod %0d ph %0d expected 0 7 -9", we_addr[0], $signed(we_mod[0]), $signed(we_ph[0]));
        end
        // avg_log2 = 7 is clamped to 4: sixteen replies of 1000 average to 1000
        clear_mon(); resp_mode = 0; resp_delay = 2;
        start_sweep(0, 0, 7, 0, 100);
        wait_done(1000, ok);
        n_vec++;
        if (!ok || ms_count !== 16 || we_mod[0] !== 32'd1000) begin
            n_bad++; $display("FAIL avg_clamp: got done %b ms %0d mod %0d expected 1 16 1000", ok, ms_count, we_mod[0]);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        clear_mon(); resp_mode = 0; resp_delay = 5; resp_skip = 2;
        start_sweep(0, 4, 0, 1, 50);
        wait_done(3000, ok);
        n_vec++;
        if (!ok || we_count !== 2 || ms_count !== 3) begin
            n_bad++; $display("FAIL tmo_counts: got done %b we %0d ms %0d expected 1 2 3", ok, we_count, ms_count);
        end
        n_vec++;
        if (we_addr[0] !== 8'd0 || we_addr[1] !== 8'd1) begin
            n_bad++; $display("FAIL tmo_addrs: got %0d %0d expected 0 1", we_addr[0], we_addr[1]);
        end
        n_vec++;
        if (done_cyc - ms_last !== 51) begin
            n_bad++; $display("FAIL tmo_latency: got %0d expected 51", done_cyc - ms_last);
        end
        n_vec++;
        if (timeout_err !== 1'b1 || points_done !== 9'd2) begin
            n_bad++; $display("FAIL tmo_flag: got terr %b pts %0d expected 1 2", timeout_err, points_done);
        end
        tick(4);
        n_vec++;
        if (timeout_err !== 1'b1) begin
            n_bad++; $display("FAIL tmo_sticky: got %b expected 1", timeout_err);
        end
        clear_mon(); resp_skip = -1;
        start_sweep(1, 0, 0, 0, 50);
        n_vec++;
        if (timeout_err !== 1'b0) begin
            n_bad++; $display("FAIL tmo_clear: got %b expected 0", timeout_err);
        end
        wait_done(20, ok);
    endtask

    task automatic test_abort();
        bit ok;
        int n = 0;
        int ab_cyc;
        clear_mon(); resp_mode = 0; resp_delay = 20;
        start_sweep(2, 5, 0, 2, 1000);
        while (ms_count == 0 && n < 100) begin tick(1); n++; end
        tick(5);
        abort = 1'b1; ab_cyc = cyc;
        tick(1);
        abort = 1'b0;
        wait_done(50, ok);
        n_vec++;
        if (!ok || done_cyc - ab_cyc !== 2) begin
            n_bad++; $display("FAIL abort_done: got done %b lat %0d expected 1 2", ok, done_cyc - ab_cyc);
        end
        tick(30);
        n_vec++;
        if (we_count !== 0 || done_count !== 1 || busy !== 1'b0 || mv_last == 0) begin
            n_bad++; $display("FAIL abort_late_valid: got we %0d done %0d busy %b expected 0 1 0", we_count, done_count, busy);
        end
        clear_mon();
        start_sweep(6, 6, 0, 0, 1000);
        n_vec++;
        if (freq_idx !== 8'd6 || busy !== 1'b1) begin
            n_bad++; $display("FAIL abort_restart: got idx %0d busy %b expected 6 1", freq_idx, busy);
        end
        wait_done(200, ok);
        n_vec++;
        if (!ok || we_count !== 1 || we_addr[0] !== 8'd0 || we_mod[0] !== 32'd1006) begin
            n_bad++; $display("FAIL abort_rerun: got we %0d addr %0d mod %0d expected 1 0 1006", we_count, we_addr[0], we_mod[0]);
        end
    endtask

    task automatic test_boundaries();
        bit ok;
        clear_mon(); resp_mode = 0; resp_delay = 3;
        start_sweep(9, 4, 0, 0, 100);
        wait_done(20, ok);
        n_vec++;
        if (!ok || done_cyc - go_cyc !== 2 || ms_count !== 0 || points_done !== 9'd0 || we_count !== 0) begin
            n_bad++; $display("FAIL empty_sweep: got lat %0d ms %0d pts %0d we %0d expected 2 0 0 0", done_cyc - go_cyc, ms_count, points_done, we_count);
        end
        clear_mon();
        start_sweep(254, 255, 0, 0, 100);
        wait_done(200, ok);
        n_vec++;
        if (!ok || we_count !== 2 || points_done !== 9'd2) begin
            n_bad++; $display("FAIL top_counts: got we %0d pts %0d expected 2 2", we_count, points_done);
        end
        n_vec++;
        if (we_addr[1] !== 8'd1 || we_mod[0] !== 32'd1254 || we_mod[1] !== 32'd1255) begin
            n_bad++; $display("FAIL top_writes: got addr %0d mods %0d %0d expected 1 1254 1255", we_addr[1], we_mod[0], we_mod[1]);
        end
        tick(5);
        n_vec++;
        if (freq_idx !== 8'd255 || ms_count !== 2) begin
            n_bad++; $display("FAIL top_no_wrap: got idx %0d ms %0d expected 255 2", freq_idx, ms_count);
        end
    endtask

    task automatic test_coincident_and_busy_go();
        bit ok;
        clear_mon(); resp_mode = 0; resp_delay = 49; resp_skip = -1;
        start_sweep(0, 1, 0, 0, 50);
        tick(10);
        cfg_first_idx = 8'd7; cfg_last_idx = 8'd7;
        go = 1'b1;
        tick(1);
        go = 1'b0;
        wait_done(1000, ok);
        n_vec++;
        if (!ok || timeout_err !== 1'b0 || we_count !== 2 || ms_count !== 2) begin
            n_bad++; $display("FAIL coinc_counts: got terr %b we %0d ms %0d expected 0 2 2", timeout_err, we_count, ms_count);
        end
        n_vec++;
        if (we_addr[0] !== 8'd0 || we_addr[1] !== 8'd1 || we_mod[0] !== 32'd1000 || we_mod[1] !== 32'd1001) begin
            n_bad++; $display("FAIL coinc_writes: got %0d/%0d %0d/%0d expected 0/1000 1/1001", we_addr[0], we_mod[0], we_addr[1], we_mod[1]);
        end
        tick(5);
        n_vec++;
        if (busy !== 1'b0 || done_count !== 1) begin
            n_bad++; $display("FAIL busy_go_ignored: got busy %b done %0d expected 0 1", busy, done_count);
        end
    endtask

    task automatic test_reset_mid();
        clear_mon(); resp_mode = 0; resp_delay = 5;
        start_sweep(3, 6, 0, 5, 100);
        tick(12);
        areset_n = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || freq_idx !== 8'd0 || meas_start !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid: got busy %b idx %0d expected 0 0", busy, freq_idx);
        end
        tick(2);
        areset_n = 1'b1;
        tick(10);
        n_vec++;
        if (done_count !== 0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_no_done: got done %0d busy %b expected 0 0", done_count, busy);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_average();
        test_timeout();
        test_abort();
        test_boundaries();
        test_coincident_and_busy_go();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
